// File: rtl/lfsr_timer_pkg.sv
// Shared types and constants for the programmable LFSR timeout timer.
// Holds the FSM state encoding, the default XNOR tap table and the lockup-state helper.
package lfsr_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Maximal-length XNOR tap masks (bit n-1 = tap n), widths 3..32
    function automatic logic [31:0] default_taps(input int unsigned w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0060;
        endcase
    endfunction

    // All-ones state of a w-bit XNOR LFSR: the lockup state
    function automatic logic [31:0] lockup_state(input int unsigned w);
        if (w >= 32)
            return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR register with synchronous load-to-seed and advance controls.
// Load (or reset) takes priority over advance.
module lfsr_core
    import lfsr_timer_pkg::*;
#(
    parameter int unsigned          WIDTH = 7,
    parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]     SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             fb;

    always_comb begin
        fb         = ~^(count_q & TAPS);
        count_next = {count_q[WIDTH-2:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst || load)
            count_q <= SEED;
        else if (advance)
            count_q <= count_next;
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_timeout_prog.sv
// Programmable LFSR timeout timer: one-shot/periodic, tick-enabled, start/abort control.
// Optional feature macro LFSR_LOCKUP_DET_EN adds all-ones term rejection and lockup recovery.
module lfsr_timeout_prog
    import lfsr_timer_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'b1100000,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tick_in,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term_cnt,
    output logic [WIDTH-1:0] count,
    output logic             timeout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] term_q;
    logic             periodic_q;
    logic             timeout_q, timeout_d;
    logic             core_load, core_adv, latch_cfg;
    logic             start_ok;

`ifdef LFSR_LOCKUP_DET_EN
    localparam logic [WIDTH-1:0] LOCKUP = WIDTH'(lockup_state(WIDTH));
    logic err_q, err_d;

    assign start_ok = (term_cnt != LOCKUP);
    assign err      = err_q;
`else
    assign start_ok = 1'b1;
    assign err      = 1'b0;
`endif

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .advance (core_adv),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            term_q     <= '0;
            periodic_q <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
`ifdef LFSR_LOCKUP_DET_EN
            err_q     <= err_d;
`endif
            if (latch_cfg) begin
                term_q     <= term_cnt;
                periodic_q <= periodic;
            end
        end
    end

    // Priority abort > start > tick; the terminal state is consumed by the tick that sees it
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_adv  = 1'b0;
        latch_cfg = 1'b0;
        timeout_d = 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
        err_d     = 1'b0;
`endif
        if (abort) begin
            state_d   = IDLE;
            core_load = 1'b1;
        end else if (start) begin
            if (start_ok) begin
                state_d   = RUN;
                core_load = 1'b1;
                latch_cfg = 1'b1;
            end
`ifdef LFSR_LOCKUP_DET_EN
            else
                err_d = 1'b1;
`endif
        end else if (state_q == RUN) begin
`ifdef LFSR_LOCKUP_DET_EN
            if (count == LOCKUP) begin
                core_load = 1'b1;
                err_d     = 1'b1;
            end else
`endif
            if (tick_in) begin
                if (count == term_q) begin
                    timeout_d = 1'b1;
                    core_load = 1'b1;
                    state_d   = periodic_q ? RUN : DONE;
                end else begin
                    core_adv = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_lfsr_timeout_prog.sv
// Directed self-checking bench for lfsr_timeout_prog (WIDTH 7, x^7+x^6+1, SEED 0).
// Lockup checks run only when LFSR_LOCKUP_DET_EN is defined.
module tb_lfsr_timeout_prog;

    logic       clk = 1'b0;
    logic       rst, start, abort, tick_in, periodic;
    logic [6:0] term_cnt;
    logic [6:0] count;
    logic       timeout, busy, done, err;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    lfsr_timeout_prog #(
        .WIDTH (7),
        .TAPS  (7'b1100000),
        .SEED  (7'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .tick_in  (tick_in),
        .periodic (periodic),
        .term_cnt (term_cnt),
        .count    (count),
        .timeout  (timeout),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [6:0] c, input logic t,
                               input logic b, input logic d);
        check({tag, ".count"},   32'(count),   32'(c));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".done"},    32'(done),    32'(d));
    endtask

    initial begin
        // Reset with disruptive inputs held
        rst = 1'b1; start = 1'b1; abort = 1'b0; tick_in = 1'b1; periodic = 1'b1;
        term_cnt = 7'h00;
        step(); step();
        check_state("reset", 7'h00, 1'b0, 1'b0, 1'b0);
        check("reset.err", 32'(err), 32'h0);
        rst = 1'b0; start = 1'b0; periodic = 1'b0;
        step();
        check_state("idle_tick_ignored", 7'h00, 1'b0, 1'b0, 1'b0);

        // One-shot, term 07: 00,01,03,07 then timeout
        term_cnt = 7'h07; start = 1'b1;
        step();
        check_state("os.start", 7'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); check_state("os.t1", 7'h01, 1'b0, 1'b1, 1'b0);
        step(); check_state("os.t2", 7'h03, 1'b0, 1'b1, 1'b0);
        step(); check_state("os.t3", 7'h07, 1'b0, 1'b1, 1'b0);
        step(); check_state("os.t4", 7'h00, 1'b1, 1'b0, 1'b1);
        step(); check_state("os.done_hold", 7'h00, 1'b0, 1'b0, 1'b1);
        abort = 1'b1;
        step(); check_state("done_abort", 7'h00, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;

        // Periodic, term 03, per-clock ticks: pulse every 3 clocks
        term_cnt = 7'h03; periodic = 1'b1; start = 1'b1;
        step(); check_state("per.start", 7'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            step(); check_state("per.a", 7'h01, 1'b0, 1'b1, 1'b0);
            step(); check_state("per.b", 7'h03, 1'b0, 1'b1, 1'b0);
            step(); check_state("per.pulse", 7'h00, 1'b1, 1'b1, 1'b0);
        end

        // Same term, tick_in high 1 of 4 cycles: period 12 clocks
        tick_in = 1'b0; start = 1'b1;
        step(); check_state("q.start", 7'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick_in = ((c % 4) == 0);
            step();
            check("q.timeout", 32'(timeout), 32'((c % 12) == 8));
            check("q.busy", 32'(busy), 32'h1);
        end
        tick_in = 1'b1; abort = 1'b1; periodic = 1'b0;
        step(); check_state("q.abort", 7'h00, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;

        // Abort when count reaches 03
        term_cnt = 7'h07; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        check_state("ab.pre", 7'h03, 1'b0, 1'b1, 1'b0);
        abort = 1'b1;
        step(); check_state("ab.idle", 7'h00, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
        step(); check_state("ab.quiet", 7'h00, 1'b0, 1'b0, 1'b0);

        // Restart mid-run with new term; later term change ignored
        term_cnt = 7'h03; start = 1'b1;
        step(); start = 1'b0;
        step(); check_state("rs.pre", 7'h01, 1'b0, 1'b1, 1'b0);
        term_cnt = 7'h07; start = 1'b1;
        step(); check_state("rs.restart", 7'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b0; term_cnt = 7'h03;
        step(); check_state("rs.t1", 7'h01, 1'b0, 1'b1, 1'b0);
        step(); check_state("rs.t2", 7'h03, 1'b0, 1'b1, 1'b0);
        step(); check_state("rs.t3", 7'h07, 1'b0, 1'b1, 1'b0);
        step(); check_state("rs.t4", 7'h00, 1'b1, 1'b0, 1'b1);

        // term == SEED: timeout on every tick
        term_cnt = 7'h00; periodic = 1'b1; start = 1'b1;
        step(); check_state("ts.start", 7'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_state("ts.pulse", 7'h00, 1'b1, 1'b1, 1'b0);
        end
        tick_in = 1'b0;
        step(); check_state("ts.no_tick", 7'h00, 1'b0, 1'b1, 1'b0);
        abort = 1'b1; start = 1'b1;
        step(); check_state("ab_st.idle", 7'h00, 1'b0, 1'b0, 1'b0);
        abort = 1'b0; start = 1'b0; periodic = 1'b0;

`ifdef LFSR_LOCKUP_DET_EN
        term_cnt = 7'h7F; start = 1'b1;
        step();
        check_state("lk.reject", 7'h00, 1'b0, 1'b0, 1'b0);
        check("lk.reject_err", 32'(err), 32'h1);
        start = 1'b0;
        step(); check("lk.err_clear", 32'(err), 32'h0);

        term_cnt = 7'h07; start = 1'b1;
        step(); start = 1'b0;
        force dut.u_core.count_q = 7'h7F;
        #1;
        release dut.u_core.count_q;
        step();
        check_state("lk.recover", 7'h00, 1'b0, 1'b1, 1'b0);
        check("lk.recover_err", 32'(err), 32'h1);
        step(); check("lk.err_pulse", 32'(err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
